memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 112 +++++++++++
 tb/tb_memory_access.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access -- memory stage of the in-order pipeline.
//
// Holds one instruction from execute. It selects between the ALU result and
// the synchronous data SRAM read data, and passes the result to writeback.
// It also forwards the pending register write to decode.
//
// Ports
//   clk              clock, rising edge
//   rstn             synchronous active-low reset
//   W_allowin        writeback can take an instruction this cycle
//   M_allowin        this stage can take an instruction this cycle
//   EM_valid         EM_BUS carries a valid instruction
//   EM_BUS[70:0]     {pc[31:0], alu_result[31:0], gr_we, dest[4:0], res_from_mem}
//   data_sram_rdata  SRAM read data; valid in the instruction's first resident cycle
//   MW_valid         MW_BUS carries a valid instruction
//   MW_BUS[69:0]     {pc[31:0], final_result[31:0], gr_we, dest[4:0]}
//   MD_for_BUS[37:0] {fwd_valid, fwd_dest[4:0], final_result[31:0]}
//   m_state[1:0]     debug view of the stage FSM: 0 EMPTY, 1 FRESH, 2 HELD
//
// Handshake: a transfer happens on a rising edge when the sender's valid and
// the receiver's allowin are both 1. Once valid is asserted, the sender holds
// the data until that edge. This stage always finishes in one cycle, so
// M_allowin = !M_valid || W_allowin.
// ---------------------------------------------------------------------------
module memory_access (
  input  logic        clk,
  input  logic        rstn,
  input  logic        W_allowin,
  output logic        M_allowin,
  input  logic        EM_valid,
  input  logic [70:0] EM_BUS,
  input  logic [31:0] data_sram_rdata,
  output logic        MW_valid,
  output logic [69:0] MW_BUS,
  output logic [37:0] MD_for_BUS,
  output logic [1:0]  m_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FRESH = 2'd1,
    S_HELD  = 2'd2
  } m_state_t;

  m_state_t    state;
  m_state_t    state_nxt;
  logic        m_valid;
  logic [70:0] em_bus_r;
  logic [31:0] rdata_buf;

  logic [31:0] pc;
  logic [31:0] alu_result;
  logic        gr_we;
  logic [4:0]  dest;
  logic        res_from_mem;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        fwd_valid;

  assign M_allowin = !m_valid || W_allowin;
  assign MW_valid  = m_valid;
  assign m_state   = state;

  // Next-state logic. When W_allowin is 1, the resident instruction leaves.
  // A new instruction can enter in the same edge, so the stage goes straight
  // back to FRESH with no bubble.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_EMPTY: if (EM_valid) state_nxt = S_FRESH;
      S_FRESH,
      S_HELD: begin
        if (W_allowin) state_nxt = EM_valid ? S_FRESH : S_EMPTY;
        else           state_nxt = S_HELD;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_EMPTY;
      m_valid   <= 1'b0;
      em_bus_r  <= '0;
      rdata_buf <= '0;
    end else begin
      state <= state_nxt;
      if (M_allowin) m_valid <= EM_valid;
      if (EM_valid && M_allowin) em_bus_r <= EM_BUS;
      // The SRAM output is only guaranteed during the first resident cycle.
      // Latch it when the stall starts, so later SRAM activity is ignored.
      if (state == S_FRESH && !W_allowin) rdata_buf <= data_sram_rdata;
    end
  end

  assign pc           = em_bus_r[70:39];
  assign alu_result   = em_bus_r[38:7];
  assign gr_we        = em_bus_r[6];
  assign dest         = em_bus_r[5:1];
  assign res_from_mem = em_bus_r[0];

  assign load_data    = (state == S_HELD) ? rdata_buf : data_sram_rdata;
  assign final_result = res_from_mem ? load_data : alu_result;

  // Writes to r0 are architecturally dropped, so they are never forwarded.
  assign fwd_valid  = m_valid && gr_we && (dest != 5'd0);

  assign MW_BUS     = {pc, final_result, gr_we, dest};
  assign MD_for_BUS = {fwd_valid, (fwd_valid ? dest : 5'd0), final_result};

endmodule

// File: tb/tb_memory_access.sv
// ---------------------------------------------------------------------------
// tb_memory_access -- bench for memory_access.
//
// Driver tasks apply one cycle of stimulus each. The reference model tracks
// whether an instruction is resident and how long it has stalled. For every
// accepted instruction it pushes the expected MW_BUS into exp_q. A separate
// monitor compares the DUT outputs against the head of exp_q every cycle,
// and pops the head when the instruction departs.
// ---------------------------------------------------------------------------
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rstn;
  logic        W_allowin;
  logic        M_allowin;
  logic        EM_valid;
  logic [70:0] EM_BUS;
  logic [31:0] data_sram_rdata;
  logic        MW_valid;
  logic [69:0] MW_BUS;
  logic [37:0] MD_for_BUS;
  logic [1:0]  m_state;

  memory_access dut (
    .clk             (clk),
    .rstn            (rstn),
    .W_allowin       (W_allowin),
    .M_allowin       (M_allowin),
    .EM_valid        (EM_valid),
    .EM_BUS          (EM_BUS),
    .data_sram_rdata (data_sram_rdata),
    .MW_valid        (MW_valid),
    .MW_BUS          (MW_BUS),
    .MD_for_BUS      (MD_for_BUS),
    .m_state         (m_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [69:0] exp_q[$];
  bit          occ     = 1'b0;   // an instruction is resident
  int          age     = 0;      // cycles resident beyond the first
  logic [31:0] cur_mem = '0;     // SRAM data belonging to resident load
  int          n_vec   = 0;
  int          n_bad   = 0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle. 'mem' is the SRAM data this instruction's load returns
  // in its first resident cycle. 'junk' is what the SRAM shows otherwise.
  task automatic cycle(input bit ev, input logic [31:0] pc, input logic [31:0] alu,
                       input bit gwe, input logic [4:0] dst, input bit rfm,
                       input logic [31:0] mem, input bit wa, input logic [31:0] junk);
    bit acc;
    bit dep;
    @(negedge clk);
    W_allowin       = wa;
    EM_valid        = ev;
    EM_BUS          = {pc, alu, gwe, dst, rfm};
    data_sram_rdata = (occ && age == 0) ? cur_mem : junk;
    acc = ev && (!occ || wa);
    dep = occ && wa;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back({pc, (rfm ? mem : alu), gwe, dst});
      occ     = 1'b1;
      age     = 0;
      cur_mem = mem;
    end else if (dep) begin
      occ = 1'b0;
    end else if (occ) begin
      age++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, $urandom, $urandom, 1'b1, 5'd1, 1'b0, $urandom, 1'b1, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    EM_valid = 1'b0;
    @(posedge clk);
    exp_q.delete();
    occ = 1'b0;
    age = 0;
    @(negedge clk);
    rstn      = 1'b1;
    W_allowin = 1'b0;
    #2;
    check("rst_mw_valid",   MW_valid,   70'd0);
    check("rst_mw_bus",     MW_BUS,     70'd0);
    check("rst_md_for_bus", MD_for_BUS, 70'd0);
    check("rst_m_allowin",  M_allowin,  70'd1);
    check("rst_m_state",    m_state,    70'd0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [69:0] e;
    logic [1:0]  exp_st;
    bit          fv;
    forever begin
      @(negedge clk);
      #2;
      if (rstn === 1'b1) begin
        exp_st = !occ ? 2'd0 : (age == 0 ? 2'd1 : 2'd2);
        check("mw_valid",  MW_valid,  occ);
        check("m_allowin", M_allowin, !occ || W_allowin);
        check("m_state",   m_state,   exp_st);
        if (occ) begin
          if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 70'd0, 70'd1);
          end else begin
            e  = exp_q[0];
            fv = e[5] && (e[4:0] != 5'd0);
            check("mw_bus",     MW_BUS,     e);
            check("md_for_bus", MD_for_BUS, {fv, (fv ? e[4:0] : 5'd0), e[37:6]});
            if (W_allowin) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn            = 1'b0;
    W_allowin       = 1'b0;
    EM_valid        = 1'b0;
    EM_BUS          = '0;
    data_sram_rdata = '0;
    do_reset();

    // ALU pass-through
    cycle(1'b1, 32'h1C000000, 32'h1234, 1'b1, 5'd5, 1'b0, 32'h0, 1'b1, 32'h55AA55AA);
    idle(2);
    // load, no stall
    cycle(1'b1, 32'h1C000004, 32'h8000, 1'b1, 5'd7, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0);
    idle(2);
    // load, stalled 3 cycles; SRAM output drops to 0 after the first cycle
    cycle(1'b1, 32'h1C000008, 32'h9000, 1'b1, 5'd9, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(2);
    // back-to-back
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1'b1, 5'(i + 1), 1'b0, 32'h0, 1'b1, 32'h0);
    idle(2);
    // write to r0 is not forwarded
    cycle(1'b1, 32'h200, 32'h77, 1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h0);
    idle(1);
    // entry attempts while stalled are ignored
    cycle(1'b1, 32'h300, 32'h11, 1'b1, 5'd3, 1'b0, 32'h0, 1'b1, 32'h0);
    cycle(1'b1, 32'h304, 32'h22, 1'b1, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 32'h308, 32'h33, 1'b1, 5'd6, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(2);
    // reset during HELD, then a fresh load
    cycle(1'b1, 32'h400, 32'h0, 1'b1, 5'd8, 1'b1, 32'h12345678, 1'b1, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFF);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFF);
    do_reset();
    cycle(1'b1, 32'h404, 32'h0, 1'b1, 5'd10, 1'b1, 32'h0BADF00D, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
    end
    idle(3);
    check("drained", 70'(exp_q.size()), 70'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
